// File: rtl/axis_video_pattern_gen_pkg.sv
// Shared encodings for the AXI4-Stream video pattern generator: modes, FSM states,
// sideband bit positions and the colour-bar table.
package axis_video_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_RAMP  = 2'd0;
    localparam mode_t MODE_SOLID = 2'd1;
    localparam mode_t MODE_BARS  = 2'd2;
    localparam mode_t MODE_GRAD  = 2'd3;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_BURST = 3'd1;
    localparam logic [2:0] S_BGAP  = 3'd2;
    localparam logic [2:0] S_LGAP  = 3'd3;
    localparam logic [2:0] S_FGAP  = 3'd4;

    localparam int SB_SOF = 0;
    localparam int SB_EOL = 1;
    localparam int SB_W   = 2;

    // {R,G,B} full-scale flags; white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [2:0] BAR_MASK [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                            3'b101, 3'b100, 3'b001, 3'b000};

    function automatic logic [2:0] bar_mask(input logic [2:0] idx);
        return BAR_MASK[idx];
    endfunction

endpackage

// File: rtl/axis_video_pattern_gen_if.sv
// AXI4-Stream video bus: pixel data plus SOF (tuser) and end-of-line (tlast).
interface axis_video_pattern_gen_if #(
    parameter int DATA_W = 24
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic              tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/axis_video_pattern_gen_pixel.sv
// Registered pixel formatter; the register only loads when a new beat is presented,
// so tdata holds steady under backpressure.
module axis_video_pixel
    import axis_video_pkg::*;
#(
    parameter int H_ACTIVE  = 640,
    parameter int COMP_W    = 8,
    parameter int RAMP_BITS = 6,
    parameter int XW        = 10,
    parameter int YW        = 9
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_load,
    input  mode_t                 i_mode,
    input  logic [3*COMP_W-1:0]   i_solid,
    input  logic [XW-1:0]         i_x,
    input  logic [YW-1:0]         i_y,
    input  logic [3*RAMP_BITS-1:0] i_ramp,
    output logic [3*COMP_W-1:0]   o_tdata
);
    localparam int RB = RAMP_BITS;

    logic [3*COMP_W-1:0] r_tdata;
    logic [3*COMP_W-1:0] w_pix;
    logic [XW+2:0]       w_x8;
    logic [2:0]          w_bar;
    logic [2:0]          w_mask;
    logic [COMP_W-1:0]   w_xc;
    logic [COMP_W-1:0]   w_yc;
    logic [COMP_W-1:0]   w_ramp_r;
    logic [COMP_W-1:0]   w_ramp_g;
    logic [COMP_W-1:0]   w_ramp_b;

    assign w_x8   = {i_x, 3'b000};
    assign w_bar  = 3'(w_x8 / (XW+3)'(H_ACTIVE));
    assign w_mask = bar_mask(w_bar);
    assign w_xc   = COMP_W'(i_x);
    assign w_yc   = COMP_W'(i_y);

    // Ramp fields are MSB-justified inside each component
    assign w_ramp_r = COMP_W'(i_ramp[3*RB-1:2*RB]) << (COMP_W - RB);
    assign w_ramp_g = COMP_W'(i_ramp[2*RB-1:RB])   << (COMP_W - RB);
    assign w_ramp_b = COMP_W'(i_ramp[RB-1:0])      << (COMP_W - RB);

    always_comb begin
        w_pix = '0;
        case (i_mode)
            MODE_RAMP:  w_pix = {w_ramp_r, w_ramp_g, w_ramp_b};
            MODE_SOLID: w_pix = i_solid;
            MODE_BARS:  w_pix = {{COMP_W{w_mask[2]}}, {COMP_W{w_mask[1]}}, {COMP_W{w_mask[0]}}};
            default:    w_pix = {w_xc, w_yc, w_xc + w_yc};
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tdata <= '0;
        end else if (i_load) begin
            r_tdata <= w_pix;
        end
    end

    assign o_tdata = r_tdata;

endmodule

// File: rtl/axis_video_pattern_gen.sv
// AXI4-Stream video pattern source: frame/line/burst sequencing FSM with exact-length
// blanking gaps, frame counting and a registered AXIS output stage.
module axis_video_pattern_gen
    import axis_video_pkg::*;
#(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int COMP_W    = 8,
    parameter int RAMP_BITS = 6,
    parameter int BURST_LEN = 4,
    parameter int BURST_GAP = 3,
    parameter int LINE_GAP  = 1750,
    parameter int FRAME_GAP = 500000
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   enable,
    input  mode_t                  mode,
    input  logic [3*COMP_W-1:0]    solid_rgb,
    input  logic [15:0]            frames_to_send,
    axis_video_pattern_gen_if.master m_axis_video,
    output logic                   busy,
    output logic                   frame_done,
    output logic [15:0]            frame_count
);
    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int RW = 3 * RAMP_BITS;
    localparam int MAX_LF  = (LINE_GAP > FRAME_GAP) ? LINE_GAP : FRAME_GAP;
    localparam int MAX_GAP = (BURST_GAP > MAX_LF) ? BURST_GAP : MAX_LF;
    localparam int GW = $clog2(MAX_GAP) + 1;

    localparam logic [XW-1:0] X_LAST  = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(V_ACTIVE - 1);
    localparam logic [BW-1:0] B_LAST  = BW'(BURST_LEN - 1);
    localparam logic [GW-1:0] BG_LOAD = GW'(BURST_GAP - 1);
    localparam logic [GW-1:0] LG_LOAD = GW'(LINE_GAP - 1);
    localparam logic [GW-1:0] FG_LOAD = GW'(FRAME_GAP - 1);

    logic [2:0]          r_state;
    logic [XW-1:0]       r_x;
    logic [YW-1:0]       r_y;
    logic [BW-1:0]       r_bcnt;
    logic [GW-1:0]       r_gap;
    logic [RW-1:0]       r_ramp;
    logic [15:0]         r_fts;
    logic [15:0]         r_frame_count;
    logic                r_frame_done;
    logic                r_busy;
    logic                r_tvalid;
    logic [SB_W-1:0]     r_side;
    mode_t               r_mode;
    logic [3*COMP_W-1:0] r_solid;

    logic [2:0]          w_state_next;
    logic [XW-1:0]       w_x_next;
    logic [YW-1:0]       w_y_next;
    logic [BW-1:0]       w_bcnt_next;
    logic [GW-1:0]       w_gap_next;
    logic [15:0]         w_fc_next;
    logic [15:0]         w_fc_inc;
    logic                w_accept;
    logic                w_load;
    logic                w_sof;
    logic                w_start;
    logic                w_frame_end;
    logic                w_stop_now;
    logic                w_stop_gap;
    logic [RW-1:0]       w_ramp_pix;
    logic [3*COMP_W-1:0] w_tdata;

    assign w_accept   = r_tvalid & m_axis_video.tready;
    assign w_fc_inc   = (r_frame_count == 16'hFFFF) ? r_frame_count : r_frame_count + 16'd1;
    assign w_stop_now = !enable || ((r_fts != 16'd0) && (w_fc_inc == r_fts));
    assign w_stop_gap = !enable || ((r_fts != 16'd0) && (r_frame_count == r_fts));

    // r_x/r_y always name the beat being presented, or the next one while in a gap
    always_comb begin
        w_state_next = r_state;
        w_x_next     = r_x;
        w_y_next     = r_y;
        w_bcnt_next  = r_bcnt;
        w_gap_next   = r_gap;
        w_fc_next    = r_frame_count;
        w_load       = 1'b0;
        w_sof        = 1'b0;
        w_start      = 1'b0;
        w_frame_end  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_start      = 1'b1;
                    w_load       = 1'b1;
                    w_sof        = 1'b1;
                    w_fc_next    = '0;
                    w_x_next     = '0;
                    w_y_next     = '0;
                    w_bcnt_next  = '0;
                    w_state_next = S_BURST;
                end
            end
            S_BURST: begin
                if (w_accept) begin
                    if (r_x == X_LAST) begin
                        w_x_next    = '0;
                        w_bcnt_next = '0;
                        if (r_y == Y_LAST) begin
                            w_y_next    = '0;
                            w_frame_end = 1'b1;
                            w_fc_next   = w_fc_inc;
                            if (FRAME_GAP != 0) begin
                                w_state_next = S_FGAP;
                                w_gap_next   = FG_LOAD;
                            end else if (w_stop_now) begin
                                w_state_next = S_IDLE;
                            end else begin
                                w_load = 1'b1;
                                w_sof  = 1'b1;
                            end
                        end else begin
                            w_y_next = r_y + 1'b1;
                            if (LINE_GAP != 0) begin
                                w_state_next = S_LGAP;
                                w_gap_next   = LG_LOAD;
                            end else begin
                                w_load = 1'b1;
                            end
                        end
                    end else begin
                        w_x_next = r_x + 1'b1;
                        if (r_bcnt == B_LAST) begin
                            w_bcnt_next = '0;
                            if (BURST_GAP != 0) begin
                                w_state_next = S_BGAP;
                                w_gap_next   = BG_LOAD;
                            end else begin
                                w_load = 1'b1;
                            end
                        end else begin
                            w_bcnt_next = r_bcnt + 1'b1;
                            w_load      = 1'b1;
                        end
                    end
                end
            end
            S_BGAP, S_LGAP: begin
                if (r_gap == '0) begin
                    w_load       = 1'b1;
                    w_state_next = S_BURST;
                end else begin
                    w_gap_next = r_gap - 1'b1;
                end
            end
            S_FGAP: begin
                if (r_gap == '0) begin
                    if (w_stop_gap) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_load       = 1'b1;
                        w_sof        = 1'b1;
                        w_state_next = S_BURST;
                    end
                end else begin
                    w_gap_next = r_gap - 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_ramp_pix = w_accept ? r_ramp + 1'b1 : r_ramp;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= S_IDLE;
            r_x           <= '0;
            r_y           <= '0;
            r_bcnt        <= '0;
            r_gap         <= '0;
            r_ramp        <= '0;
            r_fts         <= '0;
            r_frame_count <= '0;
            r_frame_done  <= 1'b0;
            r_busy        <= 1'b0;
            r_tvalid      <= 1'b0;
            r_side        <= '0;
            r_mode        <= MODE_RAMP;
            r_solid       <= '0;
        end else begin
            r_state       <= w_state_next;
            r_x           <= w_x_next;
            r_y           <= w_y_next;
            r_bcnt        <= w_bcnt_next;
            r_gap         <= w_gap_next;
            r_frame_count <= w_fc_next;
            r_frame_done  <= w_frame_end;
            r_busy        <= (w_state_next != S_IDLE);
            r_tvalid      <= (w_state_next == S_BURST);
            if (w_accept) begin
                r_ramp <= r_ramp + 1'b1;
            end
            if (w_start) begin
                r_fts <= frames_to_send;
            end
            if (w_load) begin
                r_side[SB_SOF] <= w_sof;
                r_side[SB_EOL] <= (w_x_next == X_LAST);
            end
            if (w_load && w_sof) begin
                r_mode  <= mode;
                r_solid <= solid_rgb;
            end
        end
    end

    // Mode and colour are frozen at SOF; the SOF beat itself uses the live inputs
    axis_video_pixel #(
        .H_ACTIVE  (H_ACTIVE),
        .COMP_W    (COMP_W),
        .RAMP_BITS (RAMP_BITS),
        .XW        (XW),
        .YW        (YW)
    ) u_pixel (
        .clk     (clk),
        .rstn    (rstn),
        .i_load  (w_load),
        .i_mode  (w_sof ? mode : r_mode),
        .i_solid (w_sof ? solid_rgb : r_solid),
        .i_x     (w_x_next),
        .i_y     (w_y_next),
        .i_ramp  (w_ramp_pix),
        .o_tdata (w_tdata)
    );

    assign m_axis_video.tdata  = w_tdata;
    assign m_axis_video.tvalid = r_tvalid;
    assign m_axis_video.tlast  = r_side[SB_EOL];
    assign m_axis_video.tuser  = r_side[SB_SOF];
    assign busy                = r_busy;
    assign frame_done          = r_frame_done;
    assign frame_count         = r_frame_count;

endmodule
